// File: rtl/blake2b_nonce_scheduler.sv
// Nonce-sweep sequencer for a free-running pipelined blake2b hasher: issues one nonce per
// cycle, tracks in-flight work with a latency-matched tag line and queues target hits.
module blake2b_nonce_scheduler #(
  parameter int HEADER_BITS  = 640,
  parameter int HASH_BITS    = 256,
  parameter int NONCE_BITS   = 32,
  parameter int NONCE_LSB    = 608,
  parameter int HASH_LATENCY = 96,
  parameter int RES_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [HEADER_BITS-1:0] job_header,
  input  logic [NONCE_BITS-1:0]  job_nstart,
  input  logic [NONCE_BITS-1:0]  job_nend,
  input  logic [HASH_BITS-1:0]   job_target,
  input  logic                   abort,
  output logic [HEADER_BITS-1:0] hdr_out,
  input  logic [HASH_BITS-1:0]   hash_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NONCE_BITS-1:0]  res_nonce,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(HASH_LATENCY + 1);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [NONCE_BITS-1:0] NONCE_ONE = NONCE_BITS'(1);
  localparam logic [PTR_W:0]        PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]        FIFO_FULL = (PTR_W + 1)'(RES_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [HEADER_BITS-1:0]  r_header;
  logic [HASH_BITS-1:0]    r_target;
  logic [NONCE_BITS-1:0]   r_nend;
  logic [NONCE_BITS-1:0]   r_issue_n;
  logic [NONCE_BITS-1:0]   r_ret_n;
  logic [HEADER_BITS-1:0]  r_hdr_out;
  logic [HASH_LATENCY-1:0] r_tag;
  logic [CNT_W-1:0]        r_inflight;
  logic                    r_job_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overflow;
  logic [NONCE_BITS-1:0]   r_mem [RES_DEPTH];
  logic [PTR_W:0]          r_wr_ptr;
  logic [PTR_W:0]          r_rd_ptr;

  logic                    w_accept;
  logic                    w_abort;
  logic                    w_tag_in;
  logic                    w_tag_out;
  logic                    w_ret_valid;
  logic                    w_hit;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic [PTR_W:0]          w_count;
  logic [HEADER_BITS-1:0]  w_hdr_issue;

  assign w_accept    = (r_state == S_IDLE) && job_valid;
  assign w_abort     = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_tag_in    = (r_state == S_RUN) && !abort;
  assign w_tag_out   = r_tag[HASH_LATENCY-1];
  // A tag leaving on an abort edge belongs to discarded work.
  assign w_ret_valid = w_tag_out && !w_abort;
  assign w_hit       = w_ret_valid && (hash_in <= r_target);

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_count == FIFO_FULL);
  assign w_pop   = !w_empty && res_ready;
  assign w_push  = w_hit && (!w_full || w_pop);
  assign w_drop  = w_hit && w_full && !w_pop;

  // Header template with the current issue nonce spliced in.
  always_comb begin
    w_hdr_issue = r_header;
    w_hdr_issue[NONCE_LSB +: NONCE_BITS] = r_issue_n;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (job_valid) w_state_nxt = S_RUN;
        else           w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (abort)                    w_state_nxt = S_IDLE;
        else if (r_issue_n == r_nend) w_state_nxt = S_DRAIN;
        else                          w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (abort)                        w_state_nxt = S_IDLE;
        else if (r_inflight == {CNT_W{1'b0}}) w_state_nxt = S_DONE;
        else                              w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_job_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_job_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // Job latch plus issue and return nonce counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_header  <= {HEADER_BITS{1'b0}};
      r_target  <= {HASH_BITS{1'b0}};
      r_nend    <= {NONCE_BITS{1'b0}};
      r_issue_n <= {NONCE_BITS{1'b0}};
      r_ret_n   <= {NONCE_BITS{1'b0}};
    end else if (w_accept) begin
      r_header  <= job_header;
      r_target  <= job_target;
      r_nend    <= job_nend;
      r_issue_n <= job_nstart;
      r_ret_n   <= job_nstart;
    end else begin
      if (w_tag_in)    r_issue_n <= r_issue_n + NONCE_ONE;
      else             r_issue_n <= r_issue_n;
      if (w_ret_valid) r_ret_n <= r_ret_n + NONCE_ONE;
      else             r_ret_n <= r_ret_n;
    end
  end

  // Header register toward the hasher; holds while not issuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_hdr_out <= {HEADER_BITS{1'b0}};
    else if (w_tag_in) r_hdr_out <= w_hdr_issue;
    else               r_hdr_out <= r_hdr_out;
  end

  // Latency-matched valid line and its occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag      <= {HASH_LATENCY{1'b0}};
      r_inflight <= {CNT_W{1'b0}};
    end else if (w_abort) begin
      r_tag      <= {HASH_LATENCY{1'b0}};
      r_inflight <= {CNT_W{1'b0}};
    end else begin
      r_tag <= (r_tag << 1) | HASH_LATENCY'(w_tag_in);
      case ({w_tag_in, w_tag_out})
        2'b10:   r_inflight <= r_inflight + CNT_ONE;
        2'b01:   r_inflight <= r_inflight - CNT_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Result FIFO; only reset empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) r_mem[i] <= {NONCE_BITS{1'b0}};
      r_wr_ptr <= {(PTR_W + 1){1'b0}};
      r_rd_ptr <= {(PTR_W + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= r_ret_n;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      else       r_rd_ptr <= r_rd_ptr;
    end
  end

  // Sticky drop flag, cleared by a new job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_overflow <= 1'b0;
    else if (w_accept) r_overflow <= 1'b0;
    else if (w_drop)   r_overflow <= 1'b1;
    else               r_overflow <= r_overflow;
  end

  assign job_ready = r_job_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign hdr_out   = r_hdr_out;
  assign res_valid = !w_empty;
  assign res_nonce = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule
